prio_irq_enc: RTL and testbench
===============================

// Module: prio_irq_enc
// PURPOSE
//  Parametrised, clocked successor of the 74HC148 8-to-3 priority encoder.
//  - Latches active-low request lines into pending bits, either level- or edge-triggered.
//  - Masks pending bits, then presents the highest-index unmasked pending request over a
//    valid/ready handshake.
//  - Keeps the 148-style cascade pins ei_n/out_n/gs_n/eo_n for chaining stages.
//  - Sits between peripheral request lines and the CPU interrupt-acknowledge logic.
// PARAMETERS
//  N_IN       8                 number of request lines, >=2; index N_IN-1 is highest priority
//  IDX_W      $clog2(N_IN)      width of the encoded index
//  EDGE_MODE  0                 0 = level (pending set while line low); 1 = set on falling edge
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  ei_n       in   1      cascade enable, active-low; 1 = stage disabled
//  in_n       in   N_IN   request lines, active-low, synchronous to clk
//  mask       in   N_IN   1 = line excluded from selection (its pending bit is kept)
//  irq_valid  out  1      a request is presented on irq_idx
//  irq_ready  in   1      consumer accepts the presented request
//  irq_idx    out  IDX_W  index of the presented request
//  pending    out  N_IN   pending bits, registered
//  out_n      out  IDX_W  ~irq_idx when irq_valid & !ei_n, else all ones
//  gs_n       out  1      0 when irq_valid & !ei_n, else 1
//  eo_n       out  1      0 when ei_n=0 & !irq_valid & no unmasked pending bit, else 1
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - pending=0, irq_valid=0, irq_idx=0, edge history in_q=all ones.
//   - Resulting outputs: out_n=all ones, gs_n=1, eo_n=ei_n.
//   - Reset mid-operation drops the presented request and all pending bits, with no accept.
//   - In EDGE_MODE, a line held low across reset release counts as an edge in the first
//     cycle after release.
//  Pending set term, per line i:
//   - EDGE_MODE=0: set_i = ~in_n[i].
//   - EDGE_MODE=1: set_i = in_q[i] & ~in_n[i].
//   - in_q <= in_n every cycle.
//   - pending[i] <= set_i | (pending[i] & ~clr_i).
//   - clr_i = accept & (irq_idx==i), where accept = irq_valid & irq_ready.
//   - When set and clear hit the same line in the same cycle, set wins.
//  Selection:
//   - cand = pending & ~mask & ~clr_vec.
//   - The winner is the highest set index of cand.
//  Presentation register:
//   - Loads only when ei_n=0 and (!irq_valid or accept).
//   - On load: irq_valid <= |cand; irq_idx <= winner (irq_idx holds its value when cand=0).
//   - With ei_n=1: no load. A request already presented stays valid and stable until
//     accepted, then irq_valid <= 0.
//   - irq_valid and irq_idx never change while irq_valid=1 & irq_ready=0.
//   - Back-to-back accepts: the next winner is presented in the cycle after accept, with
//     no bubble.
//  Latency:
//   - in_n low at edge t sets pending at t+1; irq_valid rises at t+2 (idle, unmasked, ei_n=0).
//  Cascade pins:
//   - out_n and gs_n are combinational from the registered irq_valid/irq_idx gated by ei_n.
//   - eo_n is combinational from ei_n, irq_valid and pending & ~mask.
//   - The ei_n->eo_n path is purely combinational, as in the 148.
//  Width rules:
//   - irq_idx is zero-extended to IDX_W.
//   - When N_IN is not a power of two, unused index codes are never produced.
// STRUCTURE
//  - Package prio_enc_pkg: MODE_LEVEL=0, MODE_EDGE=1 constants; function
//    idx_w(n)=$clog2(n).
//  - One sub-module prio_pick #(N, W): combinational highest-set-bit finder with any
//    output; instantiated once.
//  - Top holds in_q, pending, the presentation register and the cascade glue.
// TESTING
//  Unless noted: N_IN=8, ei_n=0, mask=0.
//  1 Reset: rst=1 for 2 cycles, in_n=8'h00.
//    -> pending=0, irq_valid=0, out_n=3'b111, gs_n=1.
//    -> eo_n follows ei_n (0 then 1 when ei_n toggled).
//  2 Level priority: in_n=8'b0101_1111 at edge t.
//    -> at t+2: irq_idx=7, out_n=3'b000, gs_n=0, eo_n=1.
//    Then irq_ready=0 for 5 cycles -> idx stays 7.
//    Then raise in_n[7] and pulse irq_ready -> next cycle irq_idx=5, out_n=3'b010.
//  3 Edge mode (EDGE_MODE=1): 1-cycle low pulse on in_n[2].
//    -> pending=8'h04; irq_idx=2 at t+2.
//    Accept -> pending=0, irq_valid=0, eo_n=0.
//  4 Set/clear collision (EDGE_MODE=1): idx 3 presented; a new falling edge on in_n[3]
//    lands in the accept cycle.
//    -> pending[3] stays 1; irq_valid=1 and irq_idx=3 in the next cycle.
//  5 Mask and enable: mask=8'h80, in_n[7] and in_n[1] low -> irq_idx=1.
//    Set ei_n=1 -> out_n=3'b111, gs_n=1, eo_n=1, no new loads.
//    Accept -> irq_valid=0.
//  6 Reset mid-operation: irq_valid=1, pending=8'h8A, rst=1 for 1 cycle.
//    -> next cycle irq_valid=0, pending=0, out_n=3'b111; in_n held low re-requests
//       per mode.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the clocked 148-style priority encoder.
// Provides trigger-mode codes and the index-width helper.
package prio_enc_pkg;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder.
// Ports: i_req request vector, o_idx highest set index, o_any any bit set.
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/prio_irq_enc.sv
// Clocked 8-to-3 style priority interrupt encoder with valid/ready output.
// Ports: clk/rst, ei_n, in_n, mask, irq_valid/ready/idx, pending, out_n, gs_n, eo_n.
module prio_irq_enc
  import prio_enc_pkg::*;
#(
  parameter int N_IN      = 8,
  parameter int IDX_W     = idx_w(N_IN),
  parameter int EDGE_MODE = MODE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ei_n,
  input  logic [N_IN-1:0]  in_n,
  input  logic [N_IN-1:0]  mask,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N_IN-1:0]  pending,
  output logic [IDX_W-1:0] out_n,
  output logic             gs_n,
  output logic             eo_n
);

  logic [N_IN-1:0]  r_in_q;
  logic [N_IN-1:0]  r_pending;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;

  logic [N_IN-1:0]  w_set;
  logic [N_IN-1:0]  w_clr;
  logic [N_IN-1:0]  w_cand;
  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic             w_accept;
  logic             w_load;
  logic             w_on;

  assign w_accept = r_valid & irq_ready;
  assign w_load   = ~ei_n & (~r_valid | w_accept);
  assign w_on     = r_valid & ~ei_n;

  assign w_set = (EDGE_MODE == MODE_EDGE) ?
                 (r_in_q & ~in_n) : ~in_n;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_clr[i] = w_accept & (r_idx == IDX_W'(i));
    end
  end

  // The line being accepted cannot win again this cycle.
  assign w_cand = r_pending & ~mask & ~w_clr;

  prio_pick #(
    .N (N_IN),
    .W (IDX_W)
  ) u_pick (
    .i_req (w_cand),
    .o_idx (w_win),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q    <= '1;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_in_q    <= in_n;
      // Set has priority over the accept clear.
      r_pending <= w_set | (r_pending & ~w_clr);
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) r_idx <= w_win;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign irq_valid = r_valid;
  assign irq_idx   = r_idx;
  assign pending   = r_pending;

  assign out_n = w_on ? ~r_idx : '1;
  assign gs_n  = ~w_on;
  assign eo_n  = ~(~ei_n & ~r_valid &
                   ~|(r_pending & ~mask));

endmodule

// File: tb/tb_prio_irq_enc.sv
// Randomised and directed bench for prio_irq_enc.
// Runs a level and an edge instance against a cycle model.
module tb_prio_irq_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ei_n = 1'b0;
  logic       irq_ready = 1'b0;
  logic [7:0] in_n = 8'hFF;
  logic [7:0] mask = 8'h00;

  logic       v_l, g_l, e_l, v_e, g_e, e_e;
  logic [2:0] x_l, o_l, x_e, o_e;
  logic [7:0] p_l, p_e;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] m_pend [2];
  logic       m_val  [2];
  int         m_idx  [2];
  logic [7:0] m_inq  [2];

  always #5 clk = ~clk;

  prio_irq_enc #(.N_IN(8), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .ei_n(ei_n), .in_n(in_n),
    .mask(mask), .irq_valid(v_l), .irq_ready(irq_ready),
    .irq_idx(x_l), .pending(p_l), .out_n(o_l),
    .gs_n(g_l), .eo_n(e_l)
  );

  prio_irq_enc #(.N_IN(8), .EDGE_MODE(1)) u_edg (
    .clk(clk), .rst(rst), .ei_n(ei_n), .in_n(in_n),
    .mask(mask), .irq_valid(v_e), .irq_ready(irq_ready),
    .irq_idx(x_e), .pending(p_e), .out_n(o_e),
    .gs_n(g_e), .eo_n(e_e)
  );

  task automatic model_step();
    logic [7:0] np;
    logic acc, s;
    int win;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_pend[m] = 8'h00;
        m_val[m]  = 1'b0;
        m_idx[m]  = 0;
        m_inq[m]  = 8'hFF;
      end else begin
        acc = m_val[m] && irq_ready;
        win = -1;
        for (int i = 0; i < 8; i++) begin
          s = (m == 1) ? (m_inq[m][i] && !in_n[i]) : !in_n[i];
          np[i] = s || (m_pend[m][i] && !(acc && m_idx[m] == i));
        end
        for (int i = 7; i >= 0; i--) begin
          if (win < 0 && m_pend[m][i] && !mask[i] &&
              !(acc && m_idx[m] == i))
            win = i;
        end
        if (!ei_n && (!m_val[m] || acc)) begin
          m_val[m] = (win >= 0);
          if (win >= 0) m_idx[m] = win;
        end else if (acc) begin
          m_val[m] = 1'b0;
        end
        m_pend[m] = np;
        m_inq[m]  = in_n;
      end
    end
  endtask

  function automatic logic [16:0] exp_of(int m);
    logic [2:0] ix, on;
    logic gs, eo;
    ix = 3'(m_idx[m]);
    on = (m_val[m] && !ei_n) ? ~ix : 3'b111;
    gs = !(m_val[m] && !ei_n);
    eo = !(!ei_n && !m_val[m] && ((m_pend[m] & ~mask) == 8'h00));
    return {m_val[m], ix, m_pend[m], on, gs, eo};
  endfunction

  function automatic logic [16:0] obs_of(int m);
    if (m == 0) return {v_l, x_l, p_l, o_l, g_l, e_l};
    return {v_e, x_e, p_e, o_e, g_e, e_e};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_n = 8'h00;
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (obs_of(m) !== exp_of(m))
        $display("FAIL reset_model m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
      else n_pass++;
    end
    n_chk++;
    if ({v_l, p_l, o_l, g_l, e_l} !== {1'b0, 8'h00, 3'b111, 1'b1, 1'b0})
      $display("FAIL reset_abs got=%b", {v_l, p_l, o_l, g_l, e_l});
    else n_pass++;
    ei_n = 1'b1; #1;
    n_chk++;
    if ({e_l, e_e} !== 2'b11)
      $display("FAIL reset_eo_follow got=%b exp=11", {e_l, e_e});
    else n_pass++;
    ei_n = 1'b0; in_n = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    in_n = 8'hFF; mask = 8'h00; ei_n = 1'b0; irq_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    irq_ready = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (obs_of(m) !== exp_of(m) || obs_of(m)[16] !== 1'b0)
        $display("FAIL drain m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
      else n_pass++;
    end
  endtask

  task automatic test_level();
    in_n = 8'b0101_1111;
    tick(); tick();
    n_chk++;
    if ({v_l, x_l, o_l, g_l, e_l} !== {1'b1, 3'd7, 3'b000, 1'b0, 1'b1})
      $display("FAIL level_first got=%b exp=1_111_000_0_1", {v_l, x_l, o_l, g_l, e_l});
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (obs_of(m) !== exp_of(m) || obs_of(m)[15:13] !== 3'd7)
          $display("FAIL level_hold m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
        else n_pass++;
      end
    end
    in_n[7] = 1'b1; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    n_chk++;
    if ({v_l, x_l, o_l, v_e, x_e} !== {1'b1, 3'd5, 3'b010, 1'b1, 3'd5})
      $display("FAIL level_next got=%b exp=1_101_010_1_101", {v_l, x_l, o_l, v_e, x_e});
    else n_pass++;
    drain();
  endtask

  task automatic test_edge();
    in_n[2] = 1'b0;
    tick();
    in_n[2] = 1'b1;
    n_chk++;
    if (p_e !== 8'h04) $display("FAIL edge_pend got=%h exp=04", p_e);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if ({v_e, x_e} !== {1'b1, 3'd2} || p_e !== 8'h04)
      $display("FAIL edge_present got=%b/%h exp=1010/04", {v_e, x_e}, p_e);
    else n_pass++;
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    n_chk++;
    if ({p_e, v_e, e_e} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL edge_accept got=%h/%b%b exp=00/00", p_e, v_e, e_e);
    else n_pass++;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (obs_of(m) !== exp_of(m))
        $display("FAIL edge_model m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    in_n[3] = 1'b0;
    tick();
    in_n[3] = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({v_e, x_e} !== {1'b1, 3'd3})
      $display("FAIL coll_pre got=%b exp=1011", {v_e, x_e});
    else n_pass++;
    in_n[3] = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0; in_n[3] = 1'b1;
    n_chk++;
    if (p_e[3] !== 1'b1) $display("FAIL coll_setwins got=%b exp=1", p_e[3]);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (obs_of(m) !== exp_of(m))
          $display("FAIL coll_model m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
        else n_pass++;
      end
    end
    n_chk++;
    if ({v_e, x_e} !== {1'b1, 3'd3})
      $display("FAIL coll_repres got=%b exp=1011", {v_e, x_e});
    else n_pass++;
    drain();
  endtask

  task automatic test_mask_enable();
    mask = 8'h80;
    in_n = 8'b0111_1101;
    tick(); tick();
    n_chk++;
    if ({v_l, x_l, v_e, x_e} !== {1'b1, 3'd1, 1'b1, 3'd1})
      $display("FAIL mask_sel got=%b exp=10011001", {v_l, x_l, v_e, x_e});
    else n_pass++;
    ei_n = 1'b1; #1;
    n_chk++;
    if ({o_l, g_l, e_l} !== {3'b111, 1'b1, 1'b1})
      $display("FAIL enable_off got=%b exp=11111", {o_l, g_l, e_l});
    else n_pass++;
    tick(); tick();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    n_chk++;
    if ({v_l, v_e} !== 2'b00) $display("FAIL enable_accept got=%b exp=00", {v_l, v_e});
    else n_pass++;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (obs_of(m) !== exp_of(m))
        $display("FAIL enable_model m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_mid_reset();
    in_n = 8'b0111_0101;
    tick(); tick();
    n_chk++;
    if ({v_l, p_l} !== {1'b1, 8'h8A}) $display("FAIL mid_pre got=%b/%h exp=1/8a", v_l, p_l);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({v_l, p_l, o_l, v_e, p_e} !== {1'b0, 8'h00, 3'b111, 1'b0, 8'h00})
      $display("FAIL mid_reset got=%b/%h/%b", v_l, p_l, o_l);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (obs_of(m) !== exp_of(m))
          $display("FAIL mid_rereq m=%0d got=%h exp=%h", m, obs_of(m), exp_of(m));
        else n_pass++;
      end
    end
    n_chk++;
    if ({p_e, v_e, x_e} !== {8'h8A, 1'b1, 3'd7})
      $display("FAIL mid_edge got=%h/%b%b exp=8a/1111", p_e, v_e, x_e);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_n      = 8'($urandom) | 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ei_n      = ($urandom_range(0, 7) == 0);
      irq_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 60) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (obs_of(m) !== exp_of(m))
          $display("FAIL rand c=%0d m=%0d got=%h exp=%h", c, m, obs_of(m), exp_of(m));
        else n_pass++;
      end
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_collision();
    test_mask_enable();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
